// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the EXE-stage iterative divider: operand width,
// FSM state encoding and the quotient value reported on divide-by-zero.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // MIPS leaves div-by-zero results undefined; this core returns all ones.
  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/lead_zero_count32.sv
// -----------------------------------------------------------------------------
// lead_zero_count32
// Combinational leading-zero counter used to pre-shift the dividend so the
// divider only iterates over significant bits.
// Ports:
//   value_i  [31:0]  value to scan
//   count_o  [5:0]   number of leading zeros, 32 for an all-zero input
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module lead_zero_count32 (
  input  logic [31:0] value_i,
  output logic [5:0]  count_o
);

  // Scanning upward lets the highest set bit overwrite any lower match.
  always_comb begin
    count_o = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value_i[i]) begin
        count_o = 6'(31 - i);
      end
    end
  end

endmodule

// File: rtl/exe_iter_divider.sv
// -----------------------------------------------------------------------------
// exe_iter_divider
// Iterative radix-2 restoring divider for MIPS div/divu. The dividend
// magnitude is left-aligned using a leading-zero count, so the number of
// iterations equals the number of significant dividend bits.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start_i            request, accepted only in IDLE (flush_i has priority)
//   signed_i           1 = div, 0 = divu; sampled on accept
//   dividend_i         dividend, sampled on accept
//   divisor_i          divisor, sampled on accept
//   flush_i            abort any operation in progress
//   busy_o             high in every state except IDLE
//   done_o             one-cycle pulse when results become valid
//   quotient_o         quotient (LO), held until the next result
//   remainder_o        remainder (HI), held until the next result
//   div_by_zero_o      divisor was zero, held with the results
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module exe_iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  // The leading-zero counter is fixed at 32 bits, so the count is too.
  localparam int CNT_W = 6;

  div_state_e       state_q;

  // Operands as accepted
  logic [WIDTH-1:0] op_dvd_q;
  logic [WIDTH-1:0] op_dvs_q;
  logic             op_signed_q;

  // Iteration datapath, all unsigned magnitudes
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dz_q;

  // Registered outputs
  logic             done_q;
  logic [WIDTH-1:0] quo_out_q;
  logic [WIDTH-1:0] rem_out_q;
  logic             dz_out_q;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dvs;
  logic [CNT_W-1:0] lz;
  logic [CNT_W-1:0] n_iter;
  logic [WIDTH:0]   partial;
  logic             take;
  logic [WIDTH-1:0] rem_sub;

  assign dvd_neg = op_signed_q & op_dvd_q[WIDTH-1];
  assign dvs_neg = op_signed_q & op_dvs_q[WIDTH-1];
  // Two's complement negation; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  assign abs_dvd = dvd_neg ? (~op_dvd_q + 1'b1) : op_dvd_q;
  assign abs_dvs = dvs_neg ? (~op_dvs_q + 1'b1) : op_dvs_q;

  lead_zero_count32 u_lzc (
    .value_i (abs_dvd),
    .count_o (lz)
  );

  assign n_iter = CNT_W'(WIDTH) - lz;

  // Partial remainder is one bit wider than the divisor so the compare
  // cannot overflow. The stored remainder is always below the divisor, so
  // the difference fits back into WIDTH bits.
  assign partial = {rem_q, dvd_q[WIDTH-1]};
  assign take    = (partial >= {1'b0, dvs_q});
  assign rem_sub = partial[WIDTH-1:0] - dvs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_dvd_q    <= '0;
      op_dvs_q    <= '0;
      op_signed_q <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      done_q      <= 1'b0;
      quo_out_q   <= '0;
      rem_out_q   <= '0;
      dz_out_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_i && (state_q != IDLE)) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_i && !flush_i) begin
              op_dvd_q    <= dividend_i;
              op_dvs_q    <= divisor_i;
              op_signed_q <= signed_i;
              state_q     <= PREP;
            end
          end

          PREP: begin
            q_neg_q <= dvd_neg ^ dvs_neg;
            r_neg_q <= dvd_neg;
            dz_q    <= (op_dvs_q == '0);
            dvd_q   <= abs_dvd << lz;
            dvs_q   <= abs_dvs;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= n_iter;
            if ((op_dvs_q == '0) || (n_iter == '0)) begin
              state_q <= FIX;
            end else begin
              state_q <= ITER;
            end
          end

          ITER: begin
            dvd_q <= dvd_q << 1;
            if (take) begin
              rem_q <= rem_sub;
              quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_q <= partial[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              state_q <= FIX;
            end
          end

          FIX: begin
            if (dz_q) begin
              quo_out_q <= DIV_BY_ZERO_Q;
              rem_out_q <= op_dvd_q;
              dz_out_q  <= 1'b1;
            end else begin
              quo_out_q <= q_neg_q ? (~quo_q + 1'b1) : quo_q;
              rem_out_q <= r_neg_q ? (~rem_q + 1'b1) : rem_q;
              dz_out_q  <= 1'b0;
            end
            done_q  <= 1'b1;
            state_q <= DONE;
          end

          DONE: begin
            state_q <= IDLE;
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign quotient_o    = quo_out_q;
  assign remainder_o   = rem_out_q;
  assign div_by_zero_o = dz_out_q;

endmodule

// File: tb/tb_exe_iter_divider.sv
`timescale 1ns/1ps
module tb_exe_iter_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        div_by_zero_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exe_iter_divider #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .signed_i      (signed_i),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .flush_i       (flush_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o)
  );

  // Drives one request and measures it; cycle numbers count from the accept
  // cycle (0). cyc = -1 means no done_o within the budget.
  task automatic do_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output int busy_bad);
    @(negedge clk);
    start_i = 1'b1; signed_i = sg; dividend_i = a; divisor_i = b;
    @(posedge clk);
    #1 start_i = 1'b0;
    cyc = -1; busy_bad = 0; q = '0; r = '0; dz = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (!busy_o) busy_bad++;
      if (done_o) begin
        cyc = c; q = quotient_o; r = remainder_o; dz = div_by_zero_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; flush_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_checks++; if (quotient_o !== 32'h0) begin n_fail++; $display("FAIL reset_q: got %h want 0", quotient_o); end
    n_checks++; if (remainder_o !== 32'h0) begin n_fail++; $display("FAIL reset_r: got %h want 0", remainder_o); end
    n_checks++; if (div_by_zero_o !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", div_by_zero_o); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned_short();
    int cyc, bb; logic [31:0] q, r; logic dz;
    do_op(1'b0, 32'd100, 32'd7, cyc, q, r, dz, bb);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL divu100_7_cycle: got %0d want 10", cyc); end
    n_checks++; if (q !== 32'd14) begin n_fail++; $display("FAIL divu100_7_q: got %0d want 14", q); end
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL divu100_7_r: got %0d want 2", r); end
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL divu100_7_dz: got %b want 0", dz); end
    n_checks++; if (bb !== 0) begin n_fail++; $display("FAIL divu100_7_busy: low in %0d cycles want 0", bb); end
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL divu100_7_busy_after: got %b want 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL divu100_7_done_pulse: got %b want 0", done_o); end
  endtask

  task automatic test_signed_neg();
    int cyc, bb; logic [31:0] q, r; logic dz;
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, cyc, q, r, dz, bb);
    n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL div_m7_2_cycle: got %0d want 6", cyc); end
    n_checks++; if (q !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_m7_2_q: got %h want fffffffd", q); end
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_m7_2_r: got %h want ffffffff", r); end
    do_op(1'b1, 32'd20, 32'hFFFF_FFFA, cyc, q, r, dz, bb);
    n_checks++; if (q !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_20_m6_q: got %h want fffffffd", q); end
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL div_20_m6_r: got %h want 2", r); end
  endtask

  task automatic test_most_negative();
    int cyc, bb; logic [31:0] q, r; logic dz;
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, cyc, q, r, dz, bb);
    n_checks++; if (cyc !== 35) begin n_fail++; $display("FAIL div_minneg_cycle: got %0d want 35", cyc); end
    n_checks++; if (q !== 32'h8000_0000) begin n_fail++; $display("FAIL div_minneg_q: got %h want 80000000", q); end
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL div_minneg_r: got %h want 0", r); end
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL div_minneg_dz: got %b want 0", dz); end
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, cyc, q, r, dz, bb);
    n_checks++; if (q !== 32'h0) begin n_fail++; $display("FAIL divu_minneg_q: got %h want 0", q); end
    n_checks++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL divu_minneg_r: got %h want 80000000", r); end
  endtask

  task automatic test_div_zero();
    int cyc, bb; logic [31:0] q, r; logic dz;
    do_op(1'b0, 32'd5, 32'd0, cyc, q, r, dz, bb);
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL divu5_0_cycle: got %0d want 3", cyc); end
    n_checks++; if (q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu5_0_q: got %h want ffffffff", q); end
    n_checks++; if (r !== 32'd5) begin n_fail++; $display("FAIL divu5_0_r: got %h want 5", r); end
    n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL divu5_0_dz: got %b want 1", dz); end
    do_op(1'b1, 32'hFFFF_FFF8, 32'd0, cyc, q, r, dz, bb);
    n_checks++; if (r !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL div_m8_0_r: got %h want fffffff8", r); end
    repeat (5) @(negedge clk);
    n_checks++; if (div_by_zero_o !== 1'b1) begin n_fail++; $display("FAIL dz_hold: got %b want 1", div_by_zero_o); end
    n_checks++; if (quotient_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_hold_q: got %h want ffffffff", quotient_o); end
    do_op(1'b0, 32'd0, 32'd9, cyc, q, r, dz, bb);
    n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL divu0_9_cycle: got %0d want 3", cyc); end
    n_checks++; if (q !== 32'h0) begin n_fail++; $display("FAIL divu0_9_q: got %h want 0", q); end
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL divu0_9_r: got %h want 0", r); end
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL divu0_9_dz: got %b want 0", dz); end
  endtask

  task automatic test_back_to_back();
    int d1, d2, ndone, early_low;
    logic busy36;
    logic [31:0] q1, r1, q2, r2;
    d1 = -1; d2 = -1; ndone = 0; early_low = 0; busy36 = 1'b1;
    q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'hFFFF_FFFF; divisor_i = 32'd1;
    @(posedge clk);
    // Requester keeps start_i high with the next operands while busy.
    #1 dividend_i = 32'd9; divisor_i = 32'd3;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c <= 35 && !busy_o) early_low++;
      if (c == 36) busy36 = busy_o;
      if (c == 37) start_i = 1'b0;
      if (done_o) begin
        ndone++;
        if (d1 < 0) begin d1 = c; q1 = quotient_o; r1 = remainder_o; end
        else begin d2 = c; q2 = quotient_o; r2 = remainder_o; end
      end
    end
    start_i = 1'b0;
    n_checks++; if (d1 !== 35) begin n_fail++; $display("FAIL full_len_cycle: got %0d want 35", d1); end
    n_checks++; if (q1 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL full_len_q: got %h want ffffffff", q1); end
    n_checks++; if (r1 !== 32'h0) begin n_fail++; $display("FAIL full_len_r: got %h want 0", r1); end
    n_checks++; if (early_low !== 0) begin n_fail++; $display("FAIL full_len_busy: low in %0d cycles want 0", early_low); end
    n_checks++; if (busy36 !== 1'b0) begin n_fail++; $display("FAIL idle_gap_busy: got %b want 0", busy36); end
    n_checks++; if (d2 !== 43) begin n_fail++; $display("FAIL second_op_cycle: got %0d want 43", d2); end
    n_checks++; if (q2 !== 32'd3) begin n_fail++; $display("FAIL second_op_q: got %h want 3", q2); end
    n_checks++; if (r2 !== 32'h0) begin n_fail++; $display("FAIL second_op_r: got %h want 0", r2); end
    n_checks++; if (ndone !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
  endtask

  task automatic test_flush();
    int cyc, bb, ndone; logic [31:0] q, r; logic dz;
    do_op(1'b0, 32'd50, 32'd8, cyc, q, r, dz, bb);
    n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL divu50_8_cycle: got %0d want 9", cyc); end
    n_checks++; if (q !== 32'd6 || r !== 32'd2) begin n_fail++; $display("FAIL divu50_8_qr: got %0d/%0d want 6/2", q, r); end
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (5) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy_o); end
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done_o) ndone++; end
    n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses want 0", ndone); end
    n_checks++; if (quotient_o !== 32'd6) begin n_fail++; $display("FAIL flush_q_hold: got %0d want 6", quotient_o); end
    n_checks++; if (remainder_o !== 32'd2) begin n_fail++; $display("FAIL flush_r_hold: got %0d want 2", remainder_o); end
    // flush and start together in IDLE: nothing accepted
    start_i = 1'b1; flush_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd3;
    @(posedge clk);
    #1 start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_start_idle: got busy %b want 0", busy_o); end
    do_op(1'b0, 32'd9, 32'd3, cyc, q, r, dz, bb);
    n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL divu9_3_cycle: got %0d want 7", cyc); end
    n_checks++; if (q !== 32'd3) begin n_fail++; $display("FAIL divu9_3_q: got %0d want 3", q); end
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL divu9_3_r: got %0d want 0", r); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
    n_checks++; if (quotient_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_q: got %h want 0", quotient_o); end
    n_checks++; if (remainder_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_r: got %h want 0", remainder_o); end
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done_o) ndone++; end
    n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", ndone); end
  endtask

  initial begin
    test_reset();
    test_unsigned_short();
    test_signed_neg();
    test_most_negative();
    test_div_zero();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
